// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter that shares one register-file read port among NUM_REQ requesters.
// The read data is captured into a single registered response slot with a one-hot owner.
module regfile_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         rf_sel,
  input  logic [DATA_WIDTH-1:0]         rf_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]            rsp_ready
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [NUM_REQ-1:0]    onehot;
    logic [PW-1:0]         idx;
    logic [ADDR_WIDTH-1:0] addr;
  } gnt_t;

  logic [PW-1:0]         rr_ptr;
  logic [ADDR_WIDTH-1:0] sel_q;
  logic                  slot_free;
  logic                  owner_ack;
  logic                  any_gnt;
  gnt_t                  gnt;

  // Only the current owner's rsp_ready matters, since rsp_valid is one-hot.
  assign owner_ack = |(rsp_valid & rsp_ready);
  assign slot_free = ~(|rsp_valid) | owner_ack;

  always_comb begin
    int          idx;
    logic [PW-1:0] ci;
    logic        found;
    gnt   = '0;
    idx   = 0;
    ci    = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      ci = idx[PW-1:0];
      if (!found && req_valid[ci]) begin
        gnt.onehot[ci] = 1'b1;
        gnt.idx        = ci;
        found          = 1'b1;
      end
    end
    gnt.addr = req_addr[gnt.idx*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Grant is suppressed while in reset so requesters never see a handshake then.
  assign req_ready = (slot_free && rst_n) ? gnt.onehot : '0;
  assign any_gnt   = |req_ready;
  assign rf_sel    = any_gnt ? gnt.addr : sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rr_ptr    <= '0;
      sel_q     <= '0;
    end else if (any_gnt) begin
      rsp_data  <= (gnt.addr == ADDR_WIDTH'(ZERO_REG)) ? '0 : rf_data;
      rsp_valid <= gnt.onehot;
      rr_ptr    <= (int'(gnt.idx) == NUM_REQ - 1) ? '0 : gnt.idx + PW'(1);
      sel_q     <= gnt.addr;
    end else if (owner_ack) begin
      rsp_valid <= '0;
    end
  end
endmodule
